// File: rtl/keypad_emulator.sv
// Keypad far-end model: plays back each accepted key code as bounce/press/hold/release/gap
// on active-low row returns, answering the column scan like a real 4x4 switch matrix.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 500,
    parameter int BOUNCE_CYCLES = 40,
    parameter int BOUNCE_TOGGLE = 8,
    parameter int CNT_W         = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] KeyCode,
    input  logic       KeyValid,
    output logic       KeyReady,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic       Busy,
    output logic       Pressed,
    output logic       Done
);

    typedef enum logic [2:0] {
        IDLE,
        B_ON,
        HOLD,
        B_OFF,
        GAP
    } state_t;

    localparam bit               HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TOGGLE_LAST = CNT_W'(BOUNCE_TOGGLE - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] tog_reg;
    logic [3:0]       code_reg;
    logic             pressed_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic             done_reg;
    logic [3:0]       row_reg;
    logic [3:0]       row_next;
    logic             col_hit;

    // The contact only conducts while its column is strobed low.
    assign col_hit = pressed_reg && !Col[code_reg[1:0]];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign row_next[gi] = !(col_hit && (code_reg[3:2] == 2'(gi)));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            tog_reg     <= '0;
            code_reg    <= '0;
            pressed_reg <= 1'b0;
            busy_reg    <= 1'b0;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
            row_reg     <= 4'hF;
        end else begin
            done_reg <= 1'b0;
            row_reg  <= row_next;
            case (state_reg)
                IDLE: begin
                    if (KeyValid && ready_reg) begin
                        code_reg    <= KeyCode;
                        cnt_reg     <= '0;
                        tog_reg     <= '0;
                        pressed_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        ready_reg   <= 1'b0;
                        state_reg   <= HAS_BOUNCE ? B_ON : HOLD;
                    end
                end
                B_ON, B_OFF: begin
                    if (cnt_reg == BOUNCE_LAST) begin
                        cnt_reg <= '0;
                        tog_reg <= '0;
                        if (state_reg == B_ON) begin
                            state_reg   <= HOLD;
                            pressed_reg <= 1'b1;
                        end else begin
                            state_reg   <= GAP;
                            pressed_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // Chatter: flip the contact every BOUNCE_TOGGLE cycles.
                        if (tog_reg == TOGGLE_LAST) begin
                            tog_reg     <= '0;
                            pressed_reg <= ~pressed_reg;
                        end else begin
                            tog_reg <= tog_reg + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_reg     <= '0;
                        tog_reg     <= '0;
                        pressed_reg <= 1'b0;
                        state_reg   <= HAS_BOUNCE ? B_OFF : GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign KeyReady = ready_reg;
    assign Row      = row_reg;
    assign Busy     = busy_reg;
    assign Pressed  = pressed_reg;
    assign Done     = done_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (no bounce / with bounce) checked cycle by cycle
// against a phase-arithmetic model of the contact level and row response.
module tb_keypad_emulator;

    localparam int BP [2] = '{0, 8};
    localparam int TP [2] = '{1, 2};
    localparam int HP [2] = '{10, 4};
    localparam int GP [2] = '{5, 3};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] code [2];
    logic [3:0] col [2];
    logic [3:0] row [2];
    logic       valid [2];
    logic       ready [2];
    logic       busy [2];
    logic       pressed [2];
    logic       done [2];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_CYCLES(10), .GAP_CYCLES(5), .BOUNCE_CYCLES(0),
                      .BOUNCE_TOGGLE(1), .CNT_W(8)) dut_a (
        .Clk(clk), .Reset(reset), .KeyCode(code[0]), .KeyValid(valid[0]),
        .KeyReady(ready[0]), .Col(col[0]), .Row(row[0]), .Busy(busy[0]),
        .Pressed(pressed[0]), .Done(done[0]));

    keypad_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .BOUNCE_CYCLES(8),
                      .BOUNCE_TOGGLE(2), .CNT_W(8)) dut_b (
        .Clk(clk), .Reset(reset), .KeyCode(code[1]), .KeyValid(valid[1]),
        .KeyReady(ready[1]), .Col(col[1]), .Row(row[1]), .Busy(busy[1]),
        .Pressed(pressed[1]), .Done(done[1]));

    // Contact level k cycles after the accepting edge, from the phase lengths alone.
    function automatic bit exp_pressed(int i, int k);
        int b = BP[i];
        int t = TP[i];
        int h = HP[i];
        int m = k;
        if (m < 0) return 1'b0;
        if (m < b) return ((m / t) % 2) == 0;
        m -= b;
        if (m < h) return 1'b1;
        m -= h;
        if (m < b) return ((m / t) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic int seq_len(int i);
        return 2 * BP[i] + HP[i] + GP[i];
    endfunction

    function automatic logic [3:0] exp_row(int i, int k, logic [3:0] kc, logic [3:0] pc);
        logic [3:0] one = 4'b0001;
        if (exp_pressed(i, k - 1) && !pc[kc[1:0]]) return ~(one << kc[3:2]);
        return 4'hF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (row[i] !== 4'hF) begin n_fail++; $display("FAIL reset_row[%0d]: got %h want f", i, row[i]); end
            n_checks++; if (busy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
            n_checks++; if (ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", i, ready[i]); end
            n_checks++; if (pressed[i] !== 1'b0) begin n_fail++; $display("FAIL reset_pressed[%0d]: got %b want 0", i, pressed[i]); end
            n_checks++; if (done[i] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
        end
        $display("test_reset: done");
    endtask

    task automatic test_normal_key();
        logic [3:0] kc = 4'b0110;
        logic [3:0] pc;
        int L = seq_len(0);
        int low_cycles = 0;
        code[0] = kc; col[0] = 4'b1011; valid[0] = 1'b1;
        pc = col[0];
        step();
        valid[0] = 1'b0;
        for (int k = 0; k <= L + 2; k++) begin
            n_checks++; if (pressed[0] !== exp_pressed(0, k)) begin n_fail++; $display("FAIL normal_pressed k=%0d: got %b want %b", k, pressed[0], exp_pressed(0, k)); end
            n_checks++; if (row[0] !== exp_row(0, k, kc, pc)) begin n_fail++; $display("FAIL normal_row k=%0d: got %b want %b", k, row[0], exp_row(0, k, kc, pc)); end
            n_checks++; if (done[0] !== (k == L)) begin n_fail++; $display("FAIL normal_done k=%0d: got %b want %b", k, done[0], k == L); end
            n_checks++; if (busy[0] !== (k < L)) begin n_fail++; $display("FAIL normal_busy k=%0d: got %b want %b", k, busy[0], k < L); end
            n_checks++; if (ready[0] !== (k >= L)) begin n_fail++; $display("FAIL normal_ready k=%0d: got %b want %b", k, ready[0], k >= L); end
            if (row[0] == 4'b1101) low_cycles++;
            pc = col[0];
            step();
        end
        n_checks++; if (low_cycles != 10) begin n_fail++; $display("FAIL normal_row_len: got %0d want 10", low_cycles); end
        $display("test_normal_key: row low for %0d cycles", low_cycles);
    endtask

    task automatic test_column_scan();
        logic [3:0] kc = 4'b0110;
        logic [3:0] scan [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] pc;
        logic [3:0] want;
        int L = seq_len(0);
        code[0] = kc; col[0] = scan[0]; valid[0] = 1'b1;
        pc = col[0];
        step();
        valid[0] = 1'b0;
        for (int k = 0; k <= L; k++) begin
            want = (exp_pressed(0, k - 1) && pc == 4'b1011) ? 4'b1101 : 4'hF;
            n_checks++; if (row[0] !== want) begin n_fail++; $display("FAIL scan_row k=%0d col=%b: got %b want %b", k, pc, row[0], want); end
            col[0] = scan[(k + 1) % 4];
            pc = col[0];
            step();
        end
        $display("test_column_scan: done");
    endtask

    task automatic test_bounce();
        logic [3:0] kc = 4'b1100;
        logic [3:0] pc;
        int L = seq_len(1);
        code[1] = kc; col[1] = 4'b1110; valid[1] = 1'b1;
        pc = col[1];
        step();
        valid[1] = 1'b0;
        for (int k = 0; k <= L + 1; k++) begin
            n_checks++; if (pressed[1] !== exp_pressed(1, k)) begin n_fail++; $display("FAIL bounce_pressed k=%0d: got %b want %b", k, pressed[1], exp_pressed(1, k)); end
            n_checks++; if (row[1] !== exp_row(1, k, kc, pc)) begin n_fail++; $display("FAIL bounce_row k=%0d: got %b want %b", k, row[1], exp_row(1, k, kc, pc)); end
            n_checks++; if (done[1] !== (k == L)) begin n_fail++; $display("FAIL bounce_done k=%0d: got %b want %b", k, done[1], k == L); end
            n_checks++; if (busy[1] !== (k < L)) begin n_fail++; $display("FAIL bounce_busy k=%0d: got %b want %b", k, busy[1], k < L); end
            step();
        end
        $display("test_bounce: done");
    endtask

    task automatic test_busy_reject();
        logic [3:0] kx = 4'b0110;
        logic [3:0] ky = 4'b1001;
        int L = seq_len(0);
        code[0] = kx; col[0] = 4'b0000; valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        for (int k = 0; k <= L; k++) begin
            n_checks++; if (row[0] !== exp_row(0, k, kx, 4'b0000)) begin n_fail++; $display("FAIL reject_row k=%0d: got %b want %b", k, row[0], exp_row(0, k, kx, 4'b0000)); end
            n_checks++; if (ready[0] !== (k >= L)) begin n_fail++; $display("FAIL reject_ready k=%0d: got %b want %b", k, ready[0], k >= L); end
            n_checks++; if (done[0] !== (k == L)) begin n_fail++; $display("FAIL reject_done k=%0d: got %b want %b", k, done[0], k == L); end
            if (k == 3) begin valid[0] = 1'b1; code[0] = ky; end
            step();
        end
        valid[0] = 1'b0;
        for (int k = 0; k <= L; k++) begin
            n_checks++; if (row[0] !== exp_row(0, k, ky, 4'b0000)) begin n_fail++; $display("FAIL b2b_row k=%0d: got %b want %b", k, row[0], exp_row(0, k, ky, 4'b0000)); end
            n_checks++; if (busy[0] !== (k < L)) begin n_fail++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy[0], k < L); end
            n_checks++; if (done[0] !== (k == L)) begin n_fail++; $display("FAIL b2b_done k=%0d: got %b want %b", k, done[0], k == L); end
            step();
        end
        $display("test_busy_reject: done");
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] kx = 4'b0110;
        logic [3:0] ky = 4'b0011;
        int L = seq_len(0);
        code[0] = kx; col[0] = 4'b0000; valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        step(); step(); step();
        n_checks++; if (row[0] !== 4'b1101) begin n_fail++; $display("FAIL midhold_row_before: got %b want 1101", row[0]); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (row[0] !== 4'hF) begin n_fail++; $display("FAIL midhold_row_after: got %b want f", row[0]); end
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midhold_busy: got %b want 0", busy[0]); end
        n_checks++; if (pressed[0] !== 1'b0) begin n_fail++; $display("FAIL midhold_pressed: got %b want 0", pressed[0]); end
        n_checks++; if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL midhold_ready: got %b want 1", ready[0]); end
        for (int j = 0; j < L + 2; j++) begin
            n_checks++; if (done[0] !== 1'b0) begin n_fail++; $display("FAIL midhold_no_done j=%0d: got %b want 0", j, done[0]); end
            step();
        end
        code[0] = ky; valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        for (int k = 0; k <= L; k++) begin
            n_checks++; if (row[0] !== exp_row(0, k, ky, 4'b0000)) begin n_fail++; $display("FAIL fresh_row k=%0d: got %b want %b", k, row[0], exp_row(0, k, ky, 4'b0000)); end
            n_checks++; if (done[0] !== (k == L)) begin n_fail++; $display("FAIL fresh_done k=%0d: got %b want %b", k, done[0], k == L); end
            step();
        end
        $display("test_reset_mid_hold: done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int i = int'($urandom_range(0, 1));
            int idle = int'($urandom_range(0, 2));
            int L = seq_len(i);
            logic [3:0] kc = 4'($urandom);
            logic [3:0] pc;
            for (int j = 0; j < idle; j++) begin
                col[i] = 4'($urandom);
                step();
                n_checks++; if (ready[i] !== 1'b1) begin n_fail++; $display("FAIL rand_idle_ready n=%0d: got %b want 1", n, ready[i]); end
                n_checks++; if (row[i] !== 4'hF) begin n_fail++; $display("FAIL rand_idle_row n=%0d: got %b want f", n, row[i]); end
            end
            code[i] = kc; valid[i] = 1'b1; col[i] = 4'($urandom);
            pc = col[i];
            step();
            valid[i] = 1'b0;
            for (int k = 0; k <= L; k++) begin
                n_checks++; if (pressed[i] !== exp_pressed(i, k)) begin n_fail++; $display("FAIL rand_pressed n=%0d k=%0d: got %b want %b", n, k, pressed[i], exp_pressed(i, k)); end
                n_checks++; if (row[i] !== exp_row(i, k, kc, pc)) begin n_fail++; $display("FAIL rand_row n=%0d k=%0d: got %b want %b", n, k, row[i], exp_row(i, k, kc, pc)); end
                n_checks++; if (done[i] !== (k == L)) begin n_fail++; $display("FAIL rand_done n=%0d k=%0d: got %b want %b", n, k, done[i], k == L); end
                n_checks++; if (busy[i] !== (k < L)) begin n_fail++; $display("FAIL rand_busy n=%0d k=%0d: got %b want %b", n, k, busy[i], k < L); end
                code[i] = 4'($urandom);
                col[i] = 4'($urandom);
                pc = col[i];
                if (k < L) step();
            end
            $display("test_random: key %0d inst %0d code %h idle %0d", n, i, kc, idle);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            code[i] = 4'h0;
            col[i] = 4'hF;
            valid[i] = 1'b0;
        end
        test_reset();
        test_normal_key();
        test_column_scan();
        test_bounce();
        test_busy_reject();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
